// File: rtl/vga_port_arbiter.sv
// Round-robin owner of the shared VGA framebuffer write port: one engine per burst,
// registered pixel path to the adapter, and a hold watchdog against stalled engines.
module vga_port_arbiter #(
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int C_W      = 3,
  parameter int MAX_HOLD = 19200,
  parameter int HOLD_W   = 15
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [3:0]       req,
  input  logic [3:0]       done,
  input  logic [3:0]       plot_in,
  input  logic [4*X_W-1:0] x_in,
  input  logic [4*Y_W-1:0] y_in,
  input  logic [4*C_W-1:0] c_in,
  output logic [3:0]       gnt,
  output logic [X_W-1:0]   vga_x,
  output logic [Y_W-1:0]   vga_y,
  output logic [C_W-1:0]   vga_colour,
  output logic             vga_plot,
  output logic             busy,
  output logic             timeout_err,
  output logic [1:0]       timeout_id
);

  typedef enum logic {IDLE = 1'b0, OWN = 1'b1} state_t;

  state_t            state, state_nxt;
  logic [1:0]        owner, owner_nxt;
  logic [1:0]        last, last_nxt;
  logic [1:0]        winner, cand;
  logic [HOLD_W-1:0] hold_cnt, hold_nxt;
  logic              fire;
  logic [X_W-1:0]    sel_x;
  logic [Y_W-1:0]    sel_y;
  logic [C_W-1:0]    sel_c;

  // Walk last+4 down to last+1 so the candidate nearest after last is written last and wins.
  always_comb begin
    winner = last;
    cand   = last;
    for (int k = 4; k >= 1; k--) begin
      cand = last + 2'(k);
      if (req[cand]) winner = cand;
    end
  end

  always_comb begin
    sel_x = x_in[int'(owner)*X_W +: X_W];
    sel_y = y_in[int'(owner)*Y_W +: Y_W];
    sel_c = c_in[int'(owner)*C_W +: C_W];
  end

  // NOTE: every always_comb output gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    last_nxt  = last;
    hold_nxt  = hold_cnt;
    fire      = 1'b0;
    case (state)
      IDLE: begin
        if (|req) begin
          state_nxt = OWN;
          owner_nxt = winner;
          last_nxt  = winner;
          hold_nxt  = '0;
        end
      end
      OWN: begin
        // done on the final hold cycle is a normal release, not a timeout
        fire = (hold_cnt == HOLD_W'(MAX_HOLD - 1)) && !done[owner];
        if (done[owner] || !req[owner] || fire) state_nxt = IDLE;
        else hold_nxt = hold_cnt + HOLD_W'(1);
      end
    endcase
  end

  // NOTE: reset is sampled only on the clock edge (synchronous), and all state uses non-blocking <=.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      owner       <= 2'd0;
      last        <= 2'd3;
      hold_cnt    <= '0;
      vga_x       <= '0;
      vga_y       <= '0;
      vga_colour  <= '0;
      vga_plot    <= 1'b0;
      timeout_err <= 1'b0;
      timeout_id  <= 2'd0;
    end else begin
      state    <= state_nxt;
      owner    <= owner_nxt;
      last     <= last_nxt;
      hold_cnt <= hold_nxt;
      if (state == OWN) begin
        vga_x      <= sel_x;
        vga_y      <= sel_y;
        vga_colour <= sel_c;
        vga_plot   <= plot_in[owner] & ~fire;
      end else begin
        vga_plot <= 1'b0;
      end
      if (fire) begin
        timeout_err <= 1'b1;
        timeout_id  <= owner;
      end
    end
  end

  assign busy = (state == OWN);
  assign gnt  = (state == OWN) ? (4'b0001 << owner) : 4'b0000;

endmodule

// File: tb/tb_vga_port_arbiter.sv
// Scoreboard bench for vga_port_arbiter: a behavioural model queues expected
// per-cycle status and written pixels; a monitor pops and compares them.
module tb_vga_port_arbiter;

  localparam int X_W      = 8;
  localparam int Y_W      = 7;
  localparam int C_W      = 3;
  localparam int MAX_HOLD = 8;
  localparam int HOLD_W   = 4;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic [3:0]       req = '0, done = '0, plot_in = '0;
  logic [4*X_W-1:0] x_in = '0;
  logic [4*Y_W-1:0] y_in = '0;
  logic [4*C_W-1:0] c_in = '0;
  logic [3:0]       gnt;
  logic [X_W-1:0]   vga_x;
  logic [Y_W-1:0]   vga_y;
  logic [C_W-1:0]   vga_colour;
  logic             vga_plot, busy, timeout_err;
  logic [1:0]       timeout_id;

  vga_port_arbiter #(
    .X_W(X_W), .Y_W(Y_W), .C_W(C_W), .MAX_HOLD(MAX_HOLD), .HOLD_W(HOLD_W)
  ) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .done(done), .plot_in(plot_in),
    .x_in(x_in), .y_in(y_in), .c_in(c_in), .gnt(gnt), .vga_x(vga_x),
    .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot), .busy(busy),
    .timeout_err(timeout_err), .timeout_id(timeout_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]     gnt;
    logic           busy, plot, err;
    logic [1:0]     tid;
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic [C_W-1:0] c;
  } status_t;

  typedef struct {
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic [C_W-1:0] c;
  } pix_t;

  status_t exp_q[$];
  pix_t    pix_q[$];
  int      n_checks = 0;
  int      n_pass   = 0;

  // Reference model: owner index or -1 when the port is free.
  int             m_owner = -1;
  int             m_last  = 3;
  int             m_held  = 0;
  bit             m_err   = 1'b0;
  int             m_tid   = 0;
  bit             m_plot  = 1'b0;
  logic [X_W-1:0] m_x = '0;
  logic [Y_W-1:0] m_y = '0;
  logic [C_W-1:0] m_c = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_step();
    status_t s;
    pix_t    p;
    int      o;
    bit      found, tmo;
    if (!reset_n) begin
      m_owner = -1; m_last = 3; m_held = 0; m_err = 1'b0; m_tid = 0;
      m_plot = 1'b0; m_x = '0; m_y = '0; m_c = '0;
    end else if (m_owner < 0) begin
      m_plot = 1'b0;
      found  = 1'b0;
      for (int k = 1; k <= 4; k++) begin
        if (!found && req[(m_last + k) % 4]) begin
          m_owner = (m_last + k) % 4;
          found   = 1'b1;
        end
      end
      if (found) begin
        m_last = m_owner;
        m_held = 0;
      end
    end else begin
      o   = m_owner;
      m_x = x_in[o*X_W +: X_W];
      m_y = y_in[o*Y_W +: Y_W];
      m_c = c_in[o*C_W +: C_W];
      tmo = (m_held == MAX_HOLD - 1) && !done[o];
      m_plot = plot_in[o] && !tmo;
      if (m_plot) begin
        p.x = m_x; p.y = m_y; p.c = m_c;
        pix_q.push_back(p);
      end
      if (tmo) begin
        m_err = 1'b1;
        m_tid = o;
      end
      if (done[o] || !req[o] || tmo) m_owner = -1;
      else m_held++;
    end
    s.gnt  = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
    s.busy = (m_owner >= 0);
    s.plot = m_plot;
    s.err  = m_err;
    s.tid  = 2'(m_tid);
    s.x = m_x; s.y = m_y; s.c = m_c;
    exp_q.push_back(s);
  endtask

  // Predict the coming edge from the inputs now on the pins, then wait for the next falling edge.
  task automatic step();
    model_step();
    @(negedge clk);
  endtask

  task automatic set_pix(input int e, input int x, input int y, input int c);
    x_in[e*X_W +: X_W] = X_W'(x);
    y_in[e*Y_W +: Y_W] = Y_W'(y);
    c_in[e*C_W +: C_W] = C_W'(c);
  endtask

  task automatic do_reset();
    reset_n = 1'b0; req = '0; done = '0; plot_in = '0;
    step();
    reset_n = 1'b1;
  endtask

  // Monitor: compares every cycle's status and each written pixel against the queues.
  initial begin
    status_t s;
    pix_t    p;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL status_underflow: no expectation queued at %0t", $time);
      end else begin
        s = exp_q.pop_front();
        check("gnt", gnt, s.gnt);
        check("busy", busy, s.busy);
        check("vga_plot", vga_plot, s.plot);
        check("timeout_err", timeout_err, s.err);
        check("timeout_id", timeout_id, s.tid);
        check("vga_xyc", {vga_x, vga_y, vga_colour}, {s.x, s.y, s.c});
      end
      if (vga_plot === 1'b1) begin
        if (pix_q.size() == 0) begin
          n_checks++;
          $display("FAIL pixel_unexpected: got write (%0d,%0d,%0d) expected none at %0t",
                   vga_x, vga_y, vga_colour, $time);
        end else begin
          p = pix_q.pop_front();
          check("pixel", {vga_x, vga_y, vga_colour}, {p.x, p.y, p.c});
        end
      end
    end
  end

  initial begin
    logic [3:0] rr_seq [9];
    rr_seq = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100,
               4'b0000, 4'b1000, 4'b0000, 4'b0001};

    // Reset values with all engines requesting
    reset_n = 1'b0; req = 4'hF;
    step(); step();
    check("rst_gnt", gnt, 4'b0000);
    check("rst_plot", vga_plot, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_err", timeout_err, 1'b0);
    reset_n = 1'b1;
    step();
    check("rst_first_gnt", gnt, 4'b0001);

    // Single burst from engine 0
    do_reset();
    req = 4'b0001;
    step();
    plot_in = 4'b0001;
    set_pix(0, 5, 3, 2); step();
    set_pix(0, 6, 3, 2); step();
    set_pix(0, 7, 3, 2); done = 4'b0001; step();
    check("burst_release_gnt", gnt, 4'b0000);
    done = '0; plot_in = '0; req = '0;
    step();

    // Round-robin rotation with immediate done
    do_reset();
    req = 4'hF; done = 4'hF;
    for (int i = 0; i < 9; i++) begin
      step();
      check($sformatf("rr_gnt_%0d", i), gnt, rr_seq[i]);
    end
    req = '0; done = '0;

    // No preemption: engine 1 requests and plots during engine 0's burst
    do_reset();
    req = 4'b0001;
    step();
    req = 4'b0011; plot_in = 4'b0011;
    set_pix(1, 99, 99, 7);
    set_pix(0, 10, 20, 1); step();
    check("nopre_gnt_a", gnt, 4'b0001);
    set_pix(0, 11, 20, 1); step();
    check("nopre_gnt_b", gnt, 4'b0001);
    set_pix(0, 12, 20, 1); done = 4'b0001; step();
    check("nopre_gnt_t1", gnt, 4'b0000);
    done = '0; step();
    check("nopre_gnt_t2", gnt, 4'b0010);
    req = '0; plot_in = '0;
    step();

    // Watchdog: engine 2 never finishes
    do_reset();
    req = 4'b0100; plot_in = 4'b0100;
    set_pix(2, 40, 50, 5);
    step();
    for (int i = 0; i < MAX_HOLD; i++) begin
      check($sformatf("wd_gnt_%0d", i), gnt, 4'b0100);
      set_pix(2, 60 + i, 50, 3);
      step();
    end
    check("wd_gnt_after", gnt, 4'b0000);
    check("wd_err", timeout_err, 1'b1);
    check("wd_id", timeout_id, 2'd2);
    check("wd_last_plot_dropped", vga_plot, 1'b0);
    req = '0; plot_in = '0;
    step();

    // Watchdog boundary: done on the final hold cycle is a normal release
    do_reset();
    req = 4'b0100; plot_in = 4'b0100;
    step();
    for (int i = 0; i < MAX_HOLD; i++) begin
      set_pix(2, 80 + i, 10, 6);
      if (i == MAX_HOLD - 1) done = 4'b0100;
      step();
    end
    check("wd_done_gnt", gnt, 4'b0000);
    check("wd_done_err", timeout_err, 1'b0);
    check("wd_done_plot", vga_plot, 1'b1);
    req = '0; plot_in = '0; done = '0;
    step();

    // Reset while engine 3 owns with a pixel in flight
    do_reset();
    req = 4'b1000;
    step();
    plot_in = 4'b1000; set_pix(3, 33, 44, 4);
    reset_n = 1'b0;
    step();
    check("midrst_gnt", gnt, 4'b0000);
    check("midrst_plot", vga_plot, 1'b0);
    check("midrst_busy", busy, 1'b0);
    reset_n = 1'b1; req = 4'hF; plot_in = '0;
    step();
    check("midrst_next_gnt", gnt, 4'b0001);

    // Randomized traffic against the model
    for (int n = 0; n < 2000; n++) begin
      reset_n = ($urandom_range(0, 199) != 0);
      for (int i = 0; i < 4; i++) begin
        req[i]  = ($urandom_range(0, 3) != 0);
        done[i] = ($urandom_range(0, 5) == 0);
      end
      plot_in = 4'($urandom);
      x_in    = 32'($urandom);
      y_in    = 28'($urandom);
      c_in    = 12'($urandom);
      step();
    end

    check("pix_q_drained", pix_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/vga_port_arbiter.md
# vga_port_arbiter

Shares the single VGA framebuffer write port between four drawing engines: floors, running man, eraser, and obstacles/score. It sits between those engines and the VGA adapter. It grants the port to one requester at a time for a whole burst, using round-robin priority, and registers the winner's pixel onto the adapter inputs. A hold watchdog stops a stalled engine from keeping the port forever.

## Interface
Parameters:
- X_W, 8, pixel x width
- Y_W, 7, pixel y width
- C_W, 3, colour width
- MAX_HOLD, 19200, maximum cycles one grant may last (one full 160x120 frame)
- HOLD_W, 15, hold counter width; must satisfy 2^HOLD_W > MAX_HOLD

Ports:
- clk  in  1  clock
- reset_n  in  1  reset, synchronous, active-low
- req  in  4  port request, one bit per engine (bit 0 = floors, 1 = man, 2 = eraser, 3 = obstacles)
- done  in  4  engine i's current cycle is the last of its burst
- plot_in  in  4  engine i presents a valid pixel this cycle
- x_in  in  4*X_W  packed x; engine i occupies [i*X_W +: X_W]
- y_in  in  4*Y_W  packed y, same packing
- c_in  in  4*C_W  packed colour, same packing
- gnt  out  4  one-hot grant, or all zero
- vga_x / vga_y / vga_colour  out  X_W / Y_W / C_W  registered pixel to the adapter
- vga_plot  out  1  registered write enable to the adapter
- busy  out  1  high while the port is owned
- timeout_err  out  1  sticky; set when the watchdog has fired
- timeout_id  out  2  owner index at the most recent watchdog release

## Operation
- Two states.
  - IDLE: gnt = 0.
  - OWN: gnt = onehot(owner).
- Internal registers: owner (2 b), last (2 b), hold_cnt (HOLD_W).
- IDLE, with any req bit high:
  - Pick the winner as the first set bit in the order last+1, last+2, last+3, last (mod 4).
  - owner <= winner, last <= winner, hold_cnt <= 0, go to OWN.
- IDLE, with req == 0: stay in IDLE.
- OWN, each cycle: the pixel path registers vga_x/y/colour <= owner's slice and vga_plot <= plot_in[owner].
- Release conditions in OWN (go to IDLE next cycle):
  - done[owner] = 1. That cycle's pixel is still written.
  - req[owner] = 0. That cycle's pixel is still written.
  - Watchdog: hold_cnt == MAX_HOLD-1 with no done. That cycle's pixel is discarded (vga_plot <= 0), timeout_err <= 1, timeout_id <= owner.
- Otherwise in OWN: hold_cnt increments and state stays OWN.
- Simultaneous done and watchdog: done wins. The release is normal and the error bit is not set.
- Non-owner signals in OWN (req, done, plot_in) are ignored; no preemption.
- IDLE pixel path: vga_plot <= 0, and vga_x/y/colour hold their last values.
- busy = (state == OWN). gnt and busy are decoded from registered state, with no combinational path from req.
- timeout_err is cleared only by reset.

## Timing
- Reset (synchronous, reset_n low at a rising edge):
  - state = IDLE, last = 3 (so engine 0 wins first), owner = 0, hold_cnt = 0.
  - gnt = 0, vga_x = vga_y = vga_colour = 0, vga_plot = 0, busy = 0, timeout_err = 0, timeout_id = 0.
- Grant latency: req high in IDLE cycle t gives gnt one-hot in cycle t+1.
- Pixel latency: plot_in[owner] in cycle t gives vga_plot in cycle t+1, with matching coordinates.
- Release: done in cycle t gives gnt = 0 in cycle t+1 (IDLE, arbitration) and the next gnt no earlier than cycle t+2.
  - There is always at least one gnt = 0 cycle between owners.
- Watchdog:
  - Grant asserted in cycle g.
  - Forced release evaluated in cycle g+MAX_HOLD-1.
  - gnt = 0 and timeout_err = 1 in cycle g+MAX_HOLD.
- Reset mid-ownership: the next cycle is IDLE with all outputs at reset values. A pixel in flight is dropped.

## Test plan
- Reset values: hold reset_n = 0 for 2 cycles with req = 4'b1111. Required: gnt = 0, vga_plot = 0, busy = 0, timeout_err = 0. After release, gnt = 4'b0001 one cycle after the first non-reset edge.
- Single burst:
  - Stimulus: req0 = 1; engine 0 plots (5,3,c=2), (6,3,2), (7,3,2), with done0 on the third plot.
  - Required: vga_plot high for exactly 3 cycles, each one cycle after its plot_in, with matching x/y/colour; gnt = 0 the cycle after done0.
- Round-robin: hold req = 4'b1111 and have each engine assert done on its first granted cycle. Required: grant sequence 0001, 0000, 0010, 0000, 0100, 0000, 1000, 0000, 0001.
- No preemption:
  - Stimulus: engine 0 owns; raise req1 mid-burst; done0 at cycle t.
  - Required: gnt stays 0001 through t, gnt = 0 at t+1, gnt = 0010 at t+2, and engine 1's plots during engine 0's ownership never reach vga_plot.
- Watchdog:
  - Stimulus: MAX_HOLD = 8; engine 2 granted and never asserts done.
  - Required: gnt = 0100 for 8 cycles, then 0; timeout_err = 1; timeout_id = 2; the 8th cycle's plot is not written.
  - Second case: done on the same cycle as the timeout gives timeout_err = 0.
- Reset mid-burst: assert reset_n = 0 while engine 3 owns with plot_in3 = 1. Required: the next cycle has gnt = 0, vga_plot = 0, and last = 3, so engine 0 wins next.
